// File: rtl/pifo_argsel_tree.sv
// Pipelined arg-max/arg-min over REG_WIDTH PIFO slots; latency log2(REG_WIDTH) cycles, one beat/cycle.
// Global stall: every stage holds while out_valid & !out_ready. PIFO_ARGSEL_MODE_PORT_EN adds per-beat mode_in.
module pifo_argsel_tree #(
  parameter int REG_WIDTH  = 8,
  parameter int IDX_WIDTH  = 3,
  parameter int DATA_WIDTH = 16,
  parameter int MODE       = 0
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic [REG_WIDTH*DATA_WIDTH-1:0] data_in,
  input  logic [REG_WIDTH*IDX_WIDTH-1:0]  idx_in,
  input  logic [REG_WIDTH-1:0]            vld_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH-1:0]           sel_data,
  output logic [IDX_WIDTH-1:0]            sel_idx,
  output logic                            sel_vld,
  output logic                            out_valid,
  input  logic                            out_ready
`ifdef PIFO_ARGSEL_MODE_PORT_EN
  ,
  input  logic                            mode_in
`endif
);

  localparam int S     = $clog2(REG_WIDTH);
  localparam int NODES = REG_WIDTH - 1;

  typedef struct packed {
    logic                  vld;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] data;
  } slot_t;

  function automatic slot_t pick(slot_t l, slot_t r, logic min_mode);
    slot_t res;
    logic  r_wins;
    res    = '0;
    // Strict compare so equal ranks keep the left (lower) slot.
    r_wins = min_mode ? (r.data < l.data) : (r.data > l.data);
    if (l.vld && r.vld) res = r_wins ? r : l;
    else if (l.vld)     res = l;
    else if (r.vld)     res = r;
    return res;
  endfunction

  // Heap-ordered tree: node 0 is the root, children of n are 2n+1/2n+2; leaves are the raw slots.
  slot_t        leaf     [REG_WIDTH];
  slot_t        node_q   [NODES];
  slot_t        node_nxt [NODES];
  logic [S-1:0] stg_vld;
  logic [S-1:0] vld_nxt;
  logic [S-1:0] stage_mode;
  logic         advance;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = stg_vld[S-1];
  assign sel_data  = node_q[0].data;
  assign sel_idx   = node_q[0].idx;
  assign sel_vld   = node_q[0].vld;

  for (genvar k = 0; k < REG_WIDTH; k++) begin : g_leaf
    assign leaf[k] = {vld_in[k], idx_in[k*IDX_WIDTH +: IDX_WIDTH], data_in[k*DATA_WIDTH +: DATA_WIDTH]};
  end

  for (genvar s = 0; s < S; s++) begin : g_vld
    if (s == 0) begin : g_first
      assign vld_nxt[s] = in_valid;
    end else begin : g_rest
      assign vld_nxt[s] = stg_vld[s-1];
    end
  end

`ifdef PIFO_ARGSEL_MODE_PORT_EN
  logic [S-1:0] mode_q;

  for (genvar s = 0; s < S; s++) begin : g_mode
    if (s == 0) begin : g_first
      assign stage_mode[s] = mode_in;
    end else begin : g_rest
      assign stage_mode[s] = mode_q[s-1];
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      mode_q <= '0;
    end else if (advance) begin
      mode_q <= stage_mode;
    end
  end
`else
  assign stage_mode = {S{MODE != 0}};
`endif

  for (genvar i = 0; i < NODES; i++) begin : g_node
    localparam int DEPTH = $clog2(i + 2) - 1;
    localparam int STG   = S - 1 - DEPTH;
    localparam int LC    = 2 * i + 1;
    localparam int RC    = 2 * i + 2;
    slot_t lft;
    slot_t rgt;
    if (LC >= NODES) begin : g_from_leaf
      assign lft = leaf[LC-NODES];
      assign rgt = leaf[RC-NODES];
    end else begin : g_from_node
      assign lft = node_q[LC];
      assign rgt = node_q[RC];
    end
    assign node_nxt[i] = pick(lft, rgt, stage_mode[STG]);
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      node_q  <= '{default: '0};
      stg_vld <= '0;
    end else if (advance) begin
      node_q  <= node_nxt;
      stg_vld <= vld_nxt;
    end
  end

endmodule
